// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin front end for a byte-wide SPI flash read driver.
// Each granted request reads BYTES consecutive flash bytes into a little-endian 32-bit word.
module spi_flash_arbiter #(
   parameter int BYTES      = 4,
   parameter int ADDR_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic                  p0_rstrb,
   output logic                  p0_rbusy,
   output logic [31:0]           p0_rdata,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic                  p1_rstrb,
   output logic                  p1_rbusy,
   output logic [31:0]           p1_rdata,
   output logic                  flash_sel,
   output logic                  flash_wstrb,
   output logic [31:0]           flash_wdata,
   input  logic                  flash_wbusy,
   input  logic [31:0]           flash_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_DONE} state_t;

   localparam logic [1:0] K_LAST = 2'(BYTES - 1);

   state_t                     state_q, state_d;
   logic [1:0]                 pend_q, pend_d;
   logic [1:0][ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic                       gnt_q, gnt_d;
   logic                       prio_q, prio_d;
   logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
   logic [1:0]                 k_q, k_d;
   logic [31:0]                acc_q, acc_d;
   logic [31:0]                p0_rdata_q, p0_rdata_d;
   logic [31:0]                p1_rdata_q, p1_rdata_d;
   logic [1:0]                 busy;
   logic                       unused_rdata;

   // A port stays busy from its latched strobe until the DONE edge of its own grant.
   assign busy[0] = pend_q[0] | ((state_q != S_IDLE) & ~gnt_q);
   assign busy[1] = pend_q[1] | ((state_q != S_IDLE) &  gnt_q);

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d     = state_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      gnt_d       = gnt_q;
      prio_d      = prio_q;
      cur_addr_d  = cur_addr_q;
      k_d         = k_q;
      acc_d       = acc_q;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;

      if (p0_rstrb && !busy[0]) begin
         pend_d[0]      = 1'b1;
         pend_addr_d[0] = p0_addr;
      end
      if (p1_rstrb && !busy[1]) begin
         pend_d[1]      = 1'b1;
         pend_addr_d[1] = p1_addr;
      end

      unique case (state_q)
         S_IDLE: begin
            // Waiting on wbusy lets a driver transaction orphaned by reset drain first.
            if (!flash_wbusy && pend_q != 2'b00) begin
               gnt_d          = (pend_q == 2'b11) ? prio_q : pend_q[1];
               prio_d         = ~gnt_d;
               pend_d[gnt_d]  = 1'b0;
               cur_addr_d     = pend_addr_q[gnt_d];
               k_d            = '0;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE:      state_d = S_WAIT_START;
         S_WAIT_START: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!flash_wbusy) begin
               acc_d[{k_q, 3'b000} +: 8] = flash_rdata[7:0];
               if (k_q == K_LAST) begin
                  state_d = S_DONE;
               end else begin
                  k_d        = k_q + 2'd1;
                  cur_addr_d = cur_addr_q + 1'b1;
                  state_d    = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (gnt_q) p1_rdata_d = acc_q;
            else       p0_rdata_d = acc_q;
            acc_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pend_q      <= '0;
         pend_addr_q <= '0;
         gnt_q       <= 1'b0;
         prio_q      <= 1'b0;
         cur_addr_q  <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
      end else begin
         // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         gnt_q       <= gnt_d;
         prio_q      <= prio_d;
         cur_addr_q  <= cur_addr_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
      end
   end

   assign p0_rbusy     = busy[0];
   assign p1_rbusy     = busy[1];
   assign p0_rdata     = p0_rdata_q;
   assign p1_rdata     = p1_rdata_q;
   assign flash_wstrb  = (state_q == S_ISSUE);
   // Select is also raised in the capture cycle because the driver only presents rdata under sel.
   assign flash_sel    = flash_wstrb | ((state_q == S_WAIT_DONE) & ~flash_wbusy);
   assign flash_wdata  = flash_wstrb ? {8'h00, 24'(cur_addr_q)} : 32'h0;
   assign unused_rdata = ^flash_rdata[31:8];

endmodule
